// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - shared constants and state encoding for the shared-multiplier arbiter
package mult_arb_pkg;
    localparam int N_REQ = 4;
    localparam int OPW   = 4;
    localparam int IDW   = 2;
    localparam int PW    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_OUT  = 2'b10
    } state_t;
endpackage

// File: rtl/mult4x4_array.sv
// rtl/mult4x4_array.sv - combinational 4x4 unsigned array multiplier
module mult4x4_array
    import mult_arb_pkg::*;
(
    input  logic [OPW-1:0] a_i,
    input  logic [OPW-1:0] b_i,
    output logic [PW-1:0]  p_o
);
    always_comb begin
        p_o = '0;
        // One partial-product row per multiplier bit, shifted into place.
        for (int i = 0; i < OPW; i++) begin
            p_o = p_o + ({{(PW-OPW){1'b0}}, a_i & {OPW{b_i[i]}}} << i);
        end
    end
endmodule

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - four-way round-robin picker, searching from ptr+1 upward
module rr_pick4
    import mult_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDW-1:0]   gnt_id_o
);
    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        gnt_o    = '0;
        gnt_id_o = '0;
        found    = 1'b0;
        idx      = '0;
        // The last granted requester is visited last, so nobody starves.
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ptr_i + IDW'(k);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                gnt_id_o   = idx;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mult_share_arb.sv
// rtl/mult_share_arb.sv - arbitrates four requesters onto one shared 4x4 multiplier
module mult_share_arb
    import mult_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*OPW-1:0] req_a,
    input  logic [N_REQ*OPW-1:0] req_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 res_valid,
    output logic [PW-1:0]        res_p,
    output logic [IDW-1:0]       res_id,
    input  logic                 res_ready
);
    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q;
    logic [OPW-1:0]   op_a_q, op_b_q;
    logic [IDW-1:0]   op_id_q;
    logic [PW-1:0]    res_p_q;
    logic [IDW-1:0]   res_id_q;
    logic             res_valid_q;
    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   gnt_id;
    logic [PW-1:0]    prod;
    logic             accept;

    rr_pick4 u_pick (
        .req_i    (req_valid),
        .ptr_i    (ptr_q),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    mult4x4_array u_mul (
        .a_i (op_a_q),
        .b_i (op_b_q),
        .p_o (prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = (|req_valid) ? ST_MUL : ST_IDLE;
            ST_MUL:  state_d = ST_OUT;
            ST_OUT:  state_d = (res_valid_q && res_ready) ? ST_IDLE : ST_OUT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant depends only on state, pointer and req_valid; never on res_ready.
    always_comb begin
        req_ready = '0;
        accept    = 1'b0;
        if (state_q == ST_IDLE && |req_valid) begin
            req_ready = gnt;
            accept    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= IDW'(N_REQ - 1);
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_id_q     <= '0;
            res_p_q     <= '0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                op_a_q  <= req_a[gnt_id*OPW +: OPW];
                op_b_q  <= req_b[gnt_id*OPW +: OPW];
                op_id_q <= gnt_id;
                ptr_q   <= gnt_id;
            end
            case (state_q)
                ST_MUL: begin
                    res_p_q     <= prod;
                    res_id_q    <= op_id_q;
                    res_valid_q <= 1'b1;
                end
                ST_OUT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                    end
                end
                default: res_valid_q <= 1'b0;
            endcase
        end
    end

    assign res_valid = res_valid_q;
    assign res_p     = res_p_q;
    assign res_id    = res_id_q;
endmodule

// File: tb/tb_mult_share_arb.sv
// tb/tb_mult_share_arb.sv - directed self-checking bench for mult_share_arb
module tb_mult_share_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_a, req_b;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic [7:0]  res_p;
    logic [1:0]  res_id;
    logic        res_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         id;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] gnt;
        logic [7:0] p;
    } vec_t;

    vec_t tbl [8];

    mult_share_arb dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_p     (res_p),
        .res_id    (res_id),
        .res_ready (res_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_ops(input int id, input logic [3:0] a, input logic [3:0] b);
        req_a[4*id +: 4] = a;
        req_b[4*id +: 4] = b;
    endtask

    // Second half of an operation: MUL cycle, then result cycle with res_ready high.
    task automatic finish_op(input string name, input int exp_p, input int exp_id);
        @(negedge clk);
        req_valid = 4'b0000;
        res_ready = 1'b1;
        #1;
        chk({name, " mul_ready"}, req_ready, 0);
        chk({name, " mul_valid"}, res_valid, 0);
        @(negedge clk);
        #1;
        chk({name, " res_valid"}, res_valid, 1);
        chk({name, " res_p"}, res_p, exp_p);
        chk({name, " res_id"}, res_id, exp_id);
    endtask

    task automatic do_op(input string name, input int id, input logic [3:0] a,
                         input logic [3:0] b, input int exp_gnt, input int exp_p);
        @(negedge clk);
        req_valid = 4'b0000;
        req_valid[id] = 1'b1;
        set_ops(id, a, b);
        res_ready = 1'b1;
        #1;
        chk({name, " gnt"}, req_ready, exp_gnt);
        finish_op(name, exp_p, id);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        tbl[0] = '{0, 4'd3,  4'd5,  4'b0001, 8'd15};
        tbl[1] = '{1, 4'd15, 4'd15, 4'b0010, 8'd225};
        tbl[2] = '{2, 4'd0,  4'd9,  4'b0100, 8'd0};
        tbl[3] = '{3, 4'd8,  4'd2,  4'b1000, 8'd16};
        tbl[4] = '{1, 4'd12, 4'd11, 4'b0010, 8'd132};
        tbl[5] = '{0, 4'd1,  4'd1,  4'b0001, 8'd1};
        tbl[6] = '{3, 4'd15, 4'd1,  4'b1000, 8'd15};
        tbl[7] = '{2, 4'd6,  4'd7,  4'b0100, 8'd42};

        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset req_ready", req_ready, 0);
        chk("reset res_valid", res_valid, 0);
        chk("reset res_p", res_p, 0);
        chk("reset res_id", res_id, 0);
        rst = 1'b0;

        do_op("single", 0, 4'd3, 4'd5, 4'b0001, 15);

        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("tbl%0d", i), tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].gnt, tbl[i].p);
        end

        // Round robin from reset with everyone requesting and res_ready high.
        do_reset();
        for (int i = 0; i < 4; i++) set_ops(i, 4'(i + 1), 4'(i + 2));
        req_valid = 4'b1111;
        res_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            int g;
            if (c > 0) @(negedge clk);
            #1;
            g = (c / 3) % 4;
            if (c % 3 == 0) begin
                chk($sformatf("rr gnt c%0d", c), req_ready, 1 << g);
                chk($sformatf("rr idle_valid c%0d", c), res_valid, 0);
            end else if (c % 3 == 1) begin
                chk($sformatf("rr mul_ready c%0d", c), req_ready, 0);
            end else begin
                chk($sformatf("rr res_valid c%0d", c), res_valid, 1);
                chk($sformatf("rr res_id c%0d", c), res_id, g);
                chk($sformatf("rr res_p c%0d", c), res_p, (g + 1) * (g + 2));
                chk($sformatf("rr out_ready c%0d", c), req_ready, 0);
            end
        end

        // Backpressure: result from requester 2 held for 5 cycles.
        @(negedge clk);
        req_valid = 4'b0100;
        set_ops(2, 4'd15, 4'd15);
        res_ready = 1'b0;
        #1;
        chk("bp gnt", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = 4'b0001;
        set_ops(0, 4'd2, 4'd2);
        #1;
        chk("bp mul_ready", req_ready, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("bp hold_valid %0d", c), res_valid, 1);
            chk($sformatf("bp hold_p %0d", c), res_p, 8'hE1);
            chk($sformatf("bp hold_id %0d", c), res_id, 2);
            chk($sformatf("bp hold_ready %0d", c), req_ready, 0);
        end
        @(negedge clk);
        res_ready = 1'b1;
        #1;
        chk("bp release_valid", res_valid, 1);
        chk("bp release_ready", req_ready, 0);
        @(negedge clk);
        #1;
        chk("bp back_idle_valid", res_valid, 0);
        chk("bp back_idle_gnt", req_ready, 4'b0001);
        finish_op("bp next", 4, 0);

        // Reset during MUL: requester 2 wins, so ptr would favour 3 without the reset.
        @(negedge clk);
        req_valid = 4'b0100;
        set_ops(2, 4'd7, 4'd9);
        #1;
        chk("rstmid gnt", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = 4'b0000;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstmid valid0", res_valid, 0);
        chk("rstmid p0", res_p, 0);
        @(negedge clk);
        #1;
        chk("rstmid valid1", res_valid, 0);
        @(negedge clk);
        #1;
        chk("rstmid valid2", res_valid, 0);
        @(negedge clk);
        req_valid = 4'b1010;
        set_ops(1, 4'd4, 4'd3);
        set_ops(3, 4'd5, 4'd5);
        #1;
        chk("rstmid ptr_gnt", req_ready, 4'b0010);
        finish_op("rstmid op", 12, 1);

        // Requester 1 raises and drops valid while the block is busy in OUT.
        @(negedge clk);
        req_valid = 4'b0001;
        set_ops(0, 4'd2, 4'd3);
        res_ready = 1'b0;
        #1;
        chk("vdrop gnt0", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        chk("vdrop mul_ready", req_ready, 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            req_valid = 4'b0010;
            #1;
            chk($sformatf("vdrop out_ready %0d", c), req_ready, 0);
            chk($sformatf("vdrop out_p %0d", c), res_p, 6);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        res_ready = 1'b1;
        #1;
        chk("vdrop release_valid", res_valid, 1);
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        chk("vdrop idle_ready", req_ready, 0);
        chk("vdrop idle_valid", res_valid, 0);
        @(negedge clk);
        req_valid = 4'b0110;
        set_ops(1, 4'd4, 4'd5);
        set_ops(2, 4'd1, 4'd1);
        #1;
        chk("vdrop ptr_gnt", req_ready, 4'b0010);
        finish_op("vdrop op", 20, 1);

        // Requester 3 sweeps every operand pair.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_op($sformatf("exh %0dx%0d", a, b), 3, 4'(a), 4'(b), 4'b1000, a * b);
            end
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
